// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder:
// slice width, FSM state encoding and counter sizing.
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count n items, never less than one so a single-nibble
    // adder still gets a legal counter.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder; every carry is expanded
// directly from propagate/generate terms and the carry in.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_nibble_seq_adder.sv
// WIDTH-bit adder that reuses one 4-bit lookahead slice over NIBBLES cycles,
// LS nibble first, with valid/ready handshakes on both sides.
module cla_nibble_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CW      = clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    generate
        if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
            $error("cla_nibble_seq_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] sum_d;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    cla4_slice u_slice (
        .a    (a_q[NIBBLE_W-1:0]),
        .b    (b_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign a_d = a_q >> NIBBLE_W;
    assign b_d = b_q >> NIBBLE_W;

    // Each slice result enters at the top so after NIBBLES shifts the
    // first (least significant) nibble has reached bit 0.
    generate
        if (NIBBLES == 1) begin : g_one_nibble
            assign sum_d = slice_sum;
        end else begin : g_multi_nibble
            assign sum_d = {slice_sum, sum_q[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    sum_q   <= sum_d;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cout_q  <= slice_cout;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
